// File: rtl/l1_mau_fill_if.sv
// Handshake bundles for the L1 line-fill responder: L1-side request/ack and narrow memory read bus.
interface mau_fill_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              mau_req_val;
  logic [ADDR_W-1:0] mau_req_addr;
  logic              mau_req_ack;
  logic [LINE_W-1:0] mau_ack_data;

  modport master (output mau_req_val, mau_req_addr, input mau_req_ack, mau_ack_data);
  modport slave  (input mau_req_val, mau_req_addr, output mau_req_ack, mau_ack_data);
endinterface

interface mem_rd_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req_val;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_rdy;
  logic              mem_rsp_val;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (output mem_req_val, mem_req_addr, input mem_req_rdy, mem_rsp_val, mem_rsp_data);
  modport slave  (input mem_req_val, mem_req_addr, output mem_req_rdy, mem_rsp_val, mem_rsp_data);
endinterface

// File: rtl/l1_mau_fill.sv
// L1 line-fill responder: fetches one line as BEATS pipelined word reads, assembles it,
// and returns it with a single-cycle ack.
module l1_mau_fill #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned MEM_DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mau_fill_if.slave  mau,
  mem_rd_if.master   mem,
  output logic       busy
);

  localparam int unsigned BEATS      = LINE_W / MEM_DATA_W;
  localparam int unsigned CNT_W      = $clog2(BEATS) + 1;
  localparam int unsigned OFF_W      = $clog2(LINE_W / 8);
  localparam int unsigned BEAT_BYTES = MEM_DATA_W / 8;

  localparam logic [CNT_W-1:0]  BEATS_C  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACK} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  rcvd_q, rcvd_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic              req_val;
  logic              ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      issued_q <= '0;
      rcvd_q   <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    buf_d    = buf_q;
    req_val  = 1'b0;
    ack      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mau.mau_req_val) begin
          addr_d   = mau.mau_req_addr & ~OFF_MASK;
          issued_d = '0;
          rcvd_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        // Issue and receive run independently so reads stay pipelined.
        req_val = (issued_q < BEATS_C);
        if (req_val && mem.mem_req_rdy) issued_d = issued_q + 1'b1;
        if (mem.mem_rsp_val) begin
          buf_d[int'(rcvd_q) * MEM_DATA_W +: MEM_DATA_W] = mem.mem_rsp_data;
          rcvd_d = rcvd_q + 1'b1;
          if (rcvd_q == LAST_C) state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req_val  = req_val;
  assign mem.mem_req_addr = addr_q + ADDR_W'(issued_q) * ADDR_W'(BEAT_BYTES);
  assign mau.mau_req_ack  = ack;
  assign mau.mau_ack_data = buf_q;
  assign busy             = (state_q != S_IDLE);

  rsp_within_accepted: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_FETCH && mem.mem_rsp_val) |-> (rcvd_q < issued_q));

endmodule

// File: tb/tb_l1_mau_fill.sv
// Directed bench for l1_mau_fill: 8-beat instance with a latency/ready-controlled memory model,
// plus a single-beat instance driven by hand.
module tb_l1_mau_fill;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  always #5 clk = ~clk;

  mau_fill_if #(.ADDR_W(32), .LINE_W(256)) m0 ();
  mem_rd_if   #(.ADDR_W(32), .DATA_W(32))  r0 ();
  mau_fill_if #(.ADDR_W(32), .LINE_W(256)) m1 ();
  mem_rd_if   #(.ADDR_W(32), .DATA_W(256)) r1 ();

  l1_mau_fill #(.ADDR_W(32), .LINE_W(256), .MEM_DATA_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mau(m0), .mem(r0), .busy(busy0));
  l1_mau_fill #(.ADDR_W(32), .LINE_W(256), .MEM_DATA_W(256)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mau(m1), .mem(r1), .busy(busy1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] salt = 32'h1357_9BDF;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  b;
    b = a & 32'hFFFF_FFE0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = memdata(b + 32'(i * 4));
    return l;
  endfunction

  // Memory model for the 8-beat instance: samples requests on the falling edge,
  // drives ready/response just after the rising edge.
  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t       pq[$];
  logic [31:0] acc_q[$];
  int          mcyc = 0;
  int          lat = 1;
  bit          rdy_toggle = 1'b0;
  bit          spur = 1'b0;
  int          hold_err = 0;
  bit          held = 1'b0;
  logic [31:0] held_addr = '0;

  initial begin
    r0.mem_req_rdy  = 1'b1;
    r0.mem_rsp_val  = 1'b0;
    r0.mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (held && r0.mem_req_val && r0.mem_req_addr !== held_addr) hold_err++;
      held      = r0.mem_req_val && !r0.mem_req_rdy;
      held_addr = r0.mem_req_addr;
      if (r0.mem_req_val && r0.mem_req_rdy) begin
        pq.push_back('{addr: r0.mem_req_addr, due: mcyc + lat});
        acc_q.push_back(r0.mem_req_addr);
      end
      @(posedge clk);
      #1;
      mcyc++;
      r0.mem_rsp_val = 1'b0;
      if (!rst_n) begin
        pq.delete();
      end else if (spur) begin
        r0.mem_rsp_val  = 1'b1;
        r0.mem_rsp_data = 32'hDEAD_BEEF;
        spur = 1'b0;
      end else if (pq.size() > 0 && pq[0].due <= mcyc) begin
        r0.mem_rsp_val  = 1'b1;
        r0.mem_rsp_data = memdata(pq[0].addr);
        void'(pq.pop_front());
      end
      r0.mem_req_rdy = rdy_toggle ? ~r0.mem_req_rdy : 1'b1;
    end
  end

  // Entered just after a rising edge; returns just after the rising edge following the ack.
  task automatic fill(input logic [31:0] addr, input int exp_n, input string tag,
                      output logic [255:0] line);
    int n;
    int berr;
    m0.mau_req_val  = 1'b1;
    m0.mau_req_addr = addr;
    acc_q.delete();
    n = -1;
    berr = 0;
    line = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((i == 0 && busy0 !== 1'b0) || (i > 0 && busy0 !== 1'b1)) berr++;
      if (m0.mau_req_ack === 1'b1) begin
        n = i;
        line = m0.mau_ack_data;
        break;
      end
    end
    chk({tag, "_acked"}, 256'(n >= 0), 256'(1));
    if (exp_n >= 0) chk({tag, "_lat"}, 256'(n), 256'(exp_n));
    chk({tag, "_data"}, line, line_of(addr));
    chk({tag, "_busy"}, 256'(berr), 256'(0));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 256'(m0.mau_req_ack), 256'(0));
    chk({tag, "_idle"}, 256'(busy0), 256'(0));
  endtask

  logic [255:0] line;
  logic [255:0] d1;

  initial begin
    m0.mau_req_val  = 1'b0;
    m0.mau_req_addr = '0;
    m1.mau_req_val  = 1'b0;
    m1.mau_req_addr = '0;
    r1.mem_req_rdy  = 1'b1;
    r1.mem_rsp_val  = 1'b0;
    r1.mem_rsp_data = '0;

    #2;
    chk("rst_ack", 256'(m0.mau_req_ack), 256'(0));
    chk("rst_memval", 256'(r0.mem_req_val), 256'(0));
    chk("rst_busy", 256'(busy0), 256'(0));
    chk("rst_data", m0.mau_ack_data, 256'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single fill, full-rate memory
    lat = 1;
    fill(32'h0000_1234, 10, "t1", line);
    chk("t1_nbeats", 256'(acc_q.size()), 256'(8));
    for (int i = 0; i < 8; i++)
      if (i < acc_q.size()) chk($sformatf("t1_addr%0d", i), 256'(acc_q[i]), 256'(32'h1220 + 32'(4 * i)));
    chk("t1_beat0", 256'(line[31:0]), 256'(memdata(32'h1220)));
    chk("t1_beat7", 256'(line[255:224]), 256'(memdata(32'h123C)));
    m0.mau_req_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 2: toggling ready, latency 3
    lat = 3;
    rdy_toggle = 1'b1;
    hold_err = 0;
    fill(32'h0000_3010, -1, "t2", line);
    chk("t2_hold", 256'(hold_err), 256'(0));
    chk("t2_nbeats", 256'(acc_q.size()), 256'(8));
    for (int i = 0; i < 8; i++)
      if (i < acc_q.size()) chk($sformatf("t2_addr%0d", i), 256'(acc_q[i]), 256'(32'h3000 + 32'(4 * i)));
    m0.mau_req_val = 1'b0;
    rdy_toggle = 1'b0;
    lat = 1;
    repeat (3) @(posedge clk);
    #1;

    // 3: back-to-back with request held through the ack cycle
    fill(32'h0000_1800, 10, "t3a", line);
    fill(32'h0000_2000, 10, "t3b", line);
    m0.mau_req_val = 1'b0;

    // 4: spurious response while idle
    @(negedge clk);
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_noack%0d", i), 256'(m0.mau_req_ack), 256'(0));
      chk($sformatf("t4_nobusy%0d", i), 256'(busy0), 256'(0));
    end
    chk("t4_buf", m0.mau_ack_data, line_of(32'h2000));

    // 5: reset after three beats received
    @(posedge clk);
    #1;
    m0.mau_req_val  = 1'b1;
    m0.mau_req_addr = 32'h0000_0500;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m0.mau_req_val = 1'b0;
    #1;
    chk("t5_ack", 256'(m0.mau_req_ack), 256'(0));
    chk("t5_memval", 256'(r0.mem_req_val), 256'(0));
    chk("t5_busy", 256'(busy0), 256'(0));
    chk("t5_data", m0.mau_ack_data, 256'(0));
    salt = 32'hA5A5_0F0F;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(32'h0000_0040, 10, "t5", line);
    m0.mau_req_val = 1'b0;

    // 6: single-beat instance, unaligned address
    d1 = {8{32'hC0FF_EE00}} ^ {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    @(posedge clk);
    #1;
    m1.mau_req_val  = 1'b1;
    m1.mau_req_addr = 32'h0000_001F;
    @(negedge clk);
    chk("t6_busy0", 256'(busy1), 256'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_reqval", 256'(r1.mem_req_val), 256'(1));
    chk("t6_reqaddr", 256'(r1.mem_req_addr), 256'(0));
    @(posedge clk);
    #1;
    r1.mem_rsp_val  = 1'b1;
    r1.mem_rsp_data = d1;
    @(negedge clk);
    chk("t6_noack", 256'(m1.mau_req_ack), 256'(0));
    chk("t6_noreq", 256'(r1.mem_req_val), 256'(0));
    @(posedge clk);
    #1;
    r1.mem_rsp_val = 1'b0;
    @(negedge clk);
    chk("t6_ack", 256'(m1.mau_req_ack), 256'(1));
    chk("t6_data", m1.mau_ack_data, d1);
    @(posedge clk);
    #1;
    m1.mau_req_val = 1'b0;
    @(negedge clk);
    chk("t6_pulse", 256'(m1.mau_req_ack), 256'(0));
    chk("t6_idle", 256'(busy1), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
